// File: rtl/popcount_frame_accumulator.sv
// Sums per-word popcounts over FRAME_LEN valid samples and tracks the frame maximum.
// Result is registered 1 cycle after the final sample; input is never stalled, and a frame that finds the output slot busy is dropped and flagged on sticky ovf_o.
module popcount_frame_accumulator #(
  parameter  int WIDTH     = 24,
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(WIDTH) + 1,
  localparam int SUM_W     = $clog2(WIDTH * FRAME_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             sclr_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_val_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] max_o,
  output logic             sum_val_o,
  input  logic             sum_ready_i,
  output logic [15:0]      fill_o,
  output logic             ovf_o
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic             r_rst_meta;
  logic             r_rst_n;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_mx;
  logic [15:0]      r_idx;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_max;
  logic             r_sum_val;
  logic             r_ovf;

  logic [SUM_W-1:0] w_total;
  logic [CNT_W-1:0] w_fmax;
  logic             w_last;
  logic             w_done;
  logic             w_slot_free;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  // Out-of-range counts may wrap the sum; the index logic never depends on data, so nothing can hang.
  assign w_total     = r_acc + SUM_W'(cnt_i);
  assign w_fmax      = (cnt_i > r_mx) ? cnt_i : r_mx;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_done      = cnt_val_i & w_last;
  assign w_slot_free = ~r_sum_val | sum_ready_i;

  always_ff @(posedge clk_i or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_acc     <= '0;
      r_mx      <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_sum_val <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (sclr_i) begin
      r_acc     <= '0;
      r_mx      <= '0;
      r_idx     <= '0;
      r_sum_val <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (cnt_val_i) begin
        if (w_last) begin
          r_acc <= '0;
          r_mx  <= '0;
          r_idx <= '0;
        end else begin
          r_acc <= w_total;
          r_mx  <= w_fmax;
          r_idx <= r_idx + 16'd1;
        end
      end
      if (w_done && w_slot_free) begin
        r_sum     <= w_total;
        r_max     <= w_fmax;
        r_sum_val <= 1'b1;
      end else if (w_done) begin
        r_ovf <= 1'b1;
      end else if (r_sum_val && sum_ready_i) begin
        r_sum_val <= 1'b0;
      end
    end
  end

  assign sum_o     = r_sum;
  assign max_o     = r_max;
  assign sum_val_o = r_sum_val;
  assign fill_o    = r_idx;
  assign ovf_o     = r_ovf;

endmodule

// File: doc/popcount_frame_accumulator.md
# popcount_frame_accumulator

Downstream consumer of the bit population counter. It accumulates the per-word popcount results over frames of FRAME_LEN valid samples and reports, per frame, the total set-bit sum and the maximum single-word count. Results leave through a ready/valid output register. The popcount stage has no backpressure, so this block accepts every input sample unconditionally. Back-pressure loss is reported, never hidden.

## Interface
- WIDTH, 24: word width counted upstream. Input count width CNT_W = $clog2(WIDTH)+1 (derived localparam).
- FRAME_LEN, 16: samples per frame, legal range 1..65535. SUM_W = $clog2(WIDTH*FRAME_LEN+1) (derived localparam).
- clk_i  in  1  clock; all logic on the rising edge.
- arstn_i  in  1  reset, asynchronous assertion, active-low (internally de-asserted synchronously to clk_i).
- sclr_i  in  1  synchronous clear; restarts framing.
- cnt_i  in  CNT_W  popcount of one word (upstream data_o).
- cnt_val_i  in  1  cnt_i valid (upstream data_val_o); always consumed.
- sum_o  out  SUM_W  frame sum of cnt_i.
- max_o  out  CNT_W  largest cnt_i in the frame.
- sum_val_o  out  1  sum_o/max_o valid; held until accepted.
- sum_ready_i  in  1  consumer accepts when sum_val_o & sum_ready_i.
- fill_o  out  16  samples accumulated in the current, incomplete frame.
- ovf_o  out  1  sticky: a completed frame was dropped.

## Operation
- State: accumulator acc (SUM_W), running max mx (CNT_W), sample index idx (16), output register {sum_o, max_o, sum_val_o}, ovf_o.
- Reset (arstn_i low): every register and output is 0.
- Non-final sample (cnt_val_i, idx < FRAME_LEN-1):
  - acc <= acc + cnt_i; mx <= max(mx, cnt_i); idx <= idx+1.
- Final sample (cnt_val_i, idx == FRAME_LEN-1):
  - The frame completes with total = acc + cnt_i and fmax = max(mx, cnt_i).
  - acc, mx and idx return to 0 in the same cycle, so the next sample starts a fresh frame with no bubble.
- Output register:
  - Frame completes and the output slot is free (sum_val_o=0, or sum_val_o & sum_ready_i in that cycle): load total/fmax and set sum_val_o=1.
  - Frame completes while sum_val_o=1 & sum_ready_i=0: discard the new frame, keep the old result unchanged, set ovf_o=1.
  - Handshake with no completing frame: sum_val_o <= 0. sum_o and max_o may hold stale data while sum_val_o=0.
- Arithmetic:
  - Unsigned throughout.
  - SUM_W guarantees no wrap for cnt_i <= WIDTH.
  - cnt_i > WIDTH is out of contract; behaviour is unspecified but must not hang.
- sclr_i has priority over everything and clears acc, mx, idx, sum_val_o and ovf_o.
  - A cnt_val_i in the same cycle is discarded.
  - A pending unaccepted result is dropped without setting ovf_o.
- fill_o = idx, so it always reads 0 right after frame completion.
- FRAME_LEN=1: every valid sample forms one frame (sum_o = max_o = cnt_i).
- ovf_o clears only on reset or sclr_i.

## Timing
- Latency: sum_val_o rises on the edge after the final sample's cnt_val_i cycle (1 cycle).
- Throughput: one sample per cycle, continuous.
- Back-to-back frames (FRAME_LEN=1, cnt_val_i every cycle, sum_ready_i=1): sum_val_o stays high and a new result is presented every cycle.
- sum_o/max_o remain stable while sum_val_o=1 & sum_ready_i=0.
- sum_ready_i may be high with sum_val_o=0; this has no effect.
- No combinational path from any input to any output. All outputs come straight from registers.
- arstn_i asserted mid-frame clears all state immediately (asynchronously). The first frame after release begins with the first cnt_val_i.

## Test plan
- Reset check: FRAME_LEN=4, sum_ready_i=1, cnt_i = 3,5,0,24 on consecutive cycles -> one cycle after the 4th sample: sum_o=32, max_o=24, sum_val_o=1 for one cycle, fill_o=0. Then assert arstn_i low mid-frame -> all outputs 0 at once.
- Gapped valids: FRAME_LEN=4, samples 1,2,3,4 with cnt_val_i low on alternate cycles -> sum_o=10, max_o=4. fill_o steps 1,2,3,0.
- Backpressure overflow: FRAME_LEN=2, sum_ready_i=0, frames {7,1} then {2,2} -> sum_o stays 8 with max_o=7, ovf_o=1. Raise sum_ready_i -> one handshake, then sum_val_o=0. ovf_o stays 1 until sclr_i.
- Simultaneous accept and complete: FRAME_LEN=1, sum_ready_i=1, cnt_i 9,10,11 on consecutive cycles -> sum_o 9,10,11 on consecutive cycles, sum_val_o continuously 1, ovf_o=0.
- Clear mid-frame: FRAME_LEN=4, samples 5,5 then sclr_i together with sample 6, then samples 1,1,1,1 -> sum_o=4, max_o=1. A pending result is dropped without ovf_o.
- Full-scale: WIDTH=24, FRAME_LEN=16, cnt_i=24 every cycle -> sum_o=384 with no wrap, max_o=24.
